// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// flag bundle that travels with every result.
package alu_pkg;

    localparam int OP_W = 4;

    // Codes 4'b1100..4'b1111 are deliberately absent; they decode as illegal.
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_NOT = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_SLT = 4'b0110,
        OP_EQ  = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010,
        OP_MUL = 4'b1011
    } op_e;

    // IDLE: nothing held, MUL: multiplier iterating, HOLD: result presented.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic car;
        logic of;
        logic zf;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier. One partial product is added per
// clock edge, the first one on the start edge itself, so the full 2*WIDTH
// product is available (on product_o, with done_o high) during the cycle
// that ends with the WIDTH-th edge counted from start.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_d;

    // Accumulator after the step taken on the coming edge; on the last step
    // this is the finished product, which the top registers directly.
    assign prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign busy_o    = (cnt_q != '0);
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = prod_d;

    // Load operands and take step 1 on start, then one step per edge while busy.
    always_ff @(posedge clk) begin
        // NOTE: every register here is written with <=, so all of them update
        // from the same pre-edge values regardless of statement order.
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
            prod_q   <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
            mplier_q <= b_i >> 1;
            cnt_q    <= CW'(WIDTH - 1);
        end else if (busy_o) begin
            mcand_q  <= mcand_q << 1;
            prod_q   <= prod_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on input and output.
// Single-cycle operations are computed combinationally and registered on the
// accept edge; MUL is handed to the iterative multiplier. One operation is in
// flight at a time, and a held result can be retired in the same cycle that
// the next operation is accepted.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             car,
    output logic             of,
    output logic             zf,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e             state_q;
    logic [WIDTH-1:0]   res_q;
    flags_t             flags_q;
    logic               out_valid_q;

    op_e                op_in;
    logic               accept;
    logic               start_mul;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res_d;
    flags_t             alu_flags_d;

    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign op_in     = op_e'(op);
    // Retiring a held result frees the slot in the same cycle, hence the
    // combinational out_ready -> in_ready path.
    assign in_ready  = !mul_busy &&
                       ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (op_in == OP_MUL);

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign car       = flags_q.car;
    assign of        = flags_q.of;
    assign zf        = flags_q.zf;
    assign err       = flags_q.err;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_mul),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    // Result and flags of every single-cycle operation on the current inputs.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves one unassigned and no latch is inferred.
        alu_res_d   = '0;
        alu_flags_d = '0;
        sum         = '0;
        shamt       = b[SHW-1:0];
        case (op_in)
            OP_ADD: begin
                sum            = {1'b0, a} + {1'b0, b};
                alu_res_d      = sum[WIDTH-1:0];
                alu_flags_d.car = sum[WIDTH];
                alu_flags_d.of  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // car=1 means no borrow.
                sum            = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                alu_res_d      = sum[WIDTH-1:0];
                alu_flags_d.car = sum[WIDTH];
                alu_flags_d.of  = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_NOT: alu_res_d = ~a;
            OP_AND: alu_res_d = a & b;
            OP_OR:  alu_res_d = a | b;
            OP_XOR: alu_res_d = a ^ b;
            OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  alu_res_d = {{(WIDTH-1){1'b0}}, (a == b)};
            // Amounts >= WIDTH (non power-of-two WIDTH) shift everything out.
            OP_SLL: alu_res_d = a << shamt;
            OP_SRL: alu_res_d = a >> shamt;
            OP_SRA: alu_res_d = $unsigned($signed(a) >>> shamt);
            OP_MUL: alu_res_d = '0;
            default: alu_flags_d.err = 1'b1;
        endcase
        alu_flags_d.zf = (alu_res_d == '0);
    end

    // Handshake FSM; result, flags and out_valid are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            res_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (op_in == OP_MUL) begin
                            state_q     <= ST_MUL;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_HOLD;
                            res_q       <= alu_res_d;
                            flags_q     <= alu_flags_d;
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == ST_HOLD) && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q     <= ST_HOLD;
                        res_q       <= mul_product[WIDTH-1:0];
                        flags_q.car <= |mul_product[2*WIDTH-1:WIDTH];
                        flags_q.of  <= |mul_product[2*WIDTH-1:WIDTH];
                        flags_q.zf  <= (mul_product[WIDTH-1:0] == '0);
                        flags_q.err <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
